vc_dest_scheduler: RTL and testbench
====================================

// Module: vc_dest_scheduler
// PURPOSE
// - Output-side scheduler for the four per-class FIFOs that the class arbiter fills.
// - Each cycle it picks one class FIFO whose head word can be delivered, pops it,
//   and pushes the word into one of four destination FIFOs selected by its dest field.
// - Sits between the class FIFOs and the destination FIFOs.
// - Supports round-robin or strict-priority service and keeps per-destination word counters.
// PARAMETERS
// - WORD_SIZE  12  word width; [WS-1:WS-2] class, [WS-3:WS-4] dest, [WS-5:0] payload
// - CNT_W      5   width of each per-destination delivered-word counter
// PORTS
// - clk          in   1          clock
// - reset        in   1          synchronous, active-low
// - class_data   in   4*WS       head words, FWFT; class i at [i*WS +: WS], valid when class_empty[i]=0
// - class_empty  in   4          class FIFO empty flags
// - dest_afull   in   4          destination FIFO almost-full flags
// - mode_rr      in   1          1 = round-robin, 0 = strict priority (class 0 highest)
// - pop          out  4          one-hot pop to class FIFOs
// - push         out  4          one-hot push to destination FIFOs
// - data_out     out  WS         word written to destination FIFOs
// - cnt_dest     out  4*CNT_W    words delivered per destination, dest d at [d*CNT_W +: CNT_W]
// - busy         out  1          high while state is XFER
// BEHAVIOUR
// - Reset (reset=0 at posedge): all outputs 0, state ARB, rr_ptr=3 (first RR search starts at class 0).
// - Eligibility, combinational: elig[i] = !class_empty[i] && !dest_afull[dest(class_data[i])].
// - FSM has two states: ARB and XFER.
//   - ARB with any elig: sel = grant(elig, mode_rr, rr_ptr).
//     - Next edge registers pop=onehot(sel), push=onehot(dest(word_sel)), data_out=word_sel.
//     - Increments cnt_dest[dest] and moves to XFER.
//     - In RR mode, sets rr_ptr=sel.
//   - ARB with no elig: pop=push=0, data_out holds its value, stays in ARB.
//   - XFER: pop=push=0 on the next edge; returns to ARB. Neither flag is ever high two cycles in a row.
//   - Throughput: at most one word per 2 cycles; latency from eligibility to push/pop = 1 edge.
// - Grant rules:
//   - RR: search starts at (rr_ptr+1) mod 4 and wraps; rr_ptr updates only on a grant.
//   - Strict: lowest eligible index wins. rr_ptr is not updated in strict mode.
// - mode_rr and dest_afull are sampled only in ARB. Changes during XFER take effect at the next ARB.
// - A word whose dest is almost full blocks only its own class FIFO (no head-of-line blocking across classes).
// - Counters wrap modulo 2^CNT_W and never saturate.
// - Data is never dropped or duplicated: exactly one pop and one push per granted word.
// - Reset mid-XFER: pulses clear at that edge, the FIFO sees no pop, counters go to 0.
// - Unknown or X inputs in ARB with class_empty=4'hF produce no grant.
// STRUCTURE
// - Shared include file (used with the class arbiter):
//   - localparams for the class and dest field offsets;
//   - encodings for state ARB=1'b0 and XFER=1'b1.
// - One sub-module, rr_pick4: combinational 4-way picker.
//   - Inputs: elig[3:0], ptr[1:0], mode_rr.
//   - Outputs: valid, sel[1:0].
//   - Also reusable by the class arbiter.
// - Top-level holds the FSM, rr_ptr, output registers and counters.
// TESTING
// - Reset: reset=0 for 2 cycles with all FIFOs full
//   -> pop=push=0, data_out=0, cnt_dest=0, busy=0.
// - RR fairness: all four class FIFOs non-empty, dest=0 for every word, afull=0, mode_rr=1
//   -> pop sequence 0001,0010,0100,1000,0001 on every other cycle; cnt_dest[0] increments by 1 per grant.
// - Strict priority: classes 0 and 2 non-empty, mode_rr=0
//   -> only class 0 is popped until it is empty, then class 2.
// - Dest blocking: class 0 head dest=1 with dest_afull=4'b0010, class 1 head dest=2
//   -> class 1 is served and class 0 is held; clearing afull[1] lets class 0 pop.
// - Counter wrap: 32 words to dest 3 -> cnt_dest[3] returns to 0; other counters unchanged.
// - Reset mid-XFER: assert reset in the cycle busy=1
//   -> no further pop; the word stays in its FIFO and is re-sent after reset.

Source files
------------

// File: rtl/vc_dest_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_dest_scheduler_pkg
// Description : Shared field offsets, FSM encodings and helpers for the class
//               arbiter / destination scheduler pair.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_dest_scheduler_pkg;

    // Field offsets measured down from the word MSB:
    // [WS-1:WS-2] class, [WS-3:WS-4] dest, [WS-5:0] payload
    localparam int CLASS_HI_OFS = 1;
    localparam int DEST_HI_OFS  = 3;
    localparam int FIELD_W      = 2;

    // FSM encodings
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // 2-bit index to 4-bit one-hot
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage : vc_dest_scheduler_pkg
`default_nettype wire

// File: rtl/vc_dest_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : vc_dest_scheduler_if
// Description : Bundle between the class FIFOs, the destination FIFOs and the
//               destination scheduler. master = scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vc_dest_scheduler_if #(
    parameter int WORD_SIZE = 12,
    parameter int CNT_W     = 5
);
    logic [4*WORD_SIZE-1:0] class_data;
    logic [3:0]             class_empty;
    logic [3:0]             dest_afull;
    logic                   mode_rr;
    logic [3:0]             pop;
    logic [3:0]             push;
    logic [WORD_SIZE-1:0]   data_out;
    logic [4*CNT_W-1:0]     cnt_dest;
    logic                   busy;

    modport master (
        input  class_data, class_empty, dest_afull, mode_rr,
        output pop, push, data_out, cnt_dest, busy
    );

    modport slave (
        output class_data, class_empty, dest_afull, mode_rr,
        input  pop, push, data_out, cnt_dest, busy
    );
endinterface : vc_dest_scheduler_if
`default_nettype wire

// File: rtl/vc_dest_scheduler_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way picker. Round-robin search starting one
//               past ptr, or strict priority with index 0 highest.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  wire logic [3:0] elig,
    input  wire logic [1:0] ptr,
    input  wire logic       mode_rr,
    output logic            valid,
    output logic [1:0]      sel
);

    // Scan candidates from last to first so the earliest one in search order wins
    always_comb begin
        logic [1:0] idx;
        valid = |elig;
        sel   = 2'd0;
        idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mode_rr) begin
                idx = ptr + 2'(k + 1);
            end else begin
                idx = 2'(k);
            end
            if (elig[idx]) begin
                sel = idx;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/vc_dest_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vc_dest_scheduler
// Description : Picks one deliverable class-FIFO head per grant, pops it and
//               pushes it to the destination FIFO named by its dest field.
//               Grant/transfer alternate, so at most one word per 2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_dest_scheduler
    import vc_dest_scheduler_pkg::*;
#(
    parameter int WORD_SIZE = 12,
    parameter int CNT_W     = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    vc_dest_scheduler_if.master   bus
);

    logic [WORD_SIZE-1:0] words [4];
    logic [1:0]           dests [4];
    logic [3:0]           elig;
    logic                 pick_valid;
    logic [1:0]           pick_sel;
    logic [1:0]           sel_dest;

    logic [0:0]           state;
    logic [1:0]           rr_ptr;
    logic [3:0]           pop_r;
    logic [3:0]           push_r;
    logic [WORD_SIZE-1:0] data_r;
    logic [CNT_W-1:0]     cnt_r [4];

    // A class is eligible only when its own head word can land; no
    // head-of-line blocking across classes.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_elig
            assign words[i] = bus.class_data[i*WORD_SIZE +: WORD_SIZE];
            assign dests[i] = words[i][WORD_SIZE-DEST_HI_OFS -: FIELD_W];
            assign elig[i]  = !bus.class_empty[i] && !bus.dest_afull[dests[i]];
        end
    endgenerate

    rr_pick4 u_pick (
        .elig    (elig),
        .ptr     (rr_ptr),
        .mode_rr (bus.mode_rr),
        .valid   (pick_valid),
        .sel     (pick_sel)
    );

    assign sel_dest = dests[pick_sel];

    // Grant in ARB, idle one cycle in XFER so pulses never repeat back to back
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_ARB;
            rr_ptr <= 2'd3;
            pop_r  <= 4'b0000;
            push_r <= 4'b0000;
            data_r <= '0;
            for (int d = 0; d < 4; d++) begin
                cnt_r[d] <= '0;
            end
        end else begin
            case (state)
                ST_ARB: begin
                    if (pick_valid) begin
                        pop_r           <= onehot4(pick_sel);
                        push_r          <= onehot4(sel_dest);
                        data_r          <= words[pick_sel];
                        cnt_r[sel_dest] <= cnt_r[sel_dest] + CNT_W'(1);
                        state           <= ST_XFER;
                        if (bus.mode_rr) begin
                            rr_ptr <= pick_sel;
                        end
                    end else begin
                        pop_r  <= 4'b0000;
                        push_r <= 4'b0000;
                    end
                end
                default: begin
                    pop_r  <= 4'b0000;
                    push_r <= 4'b0000;
                    state  <= ST_ARB;
                end
            endcase
        end
    end

    assign bus.pop      = pop_r;
    assign bus.push     = push_r;
    assign bus.data_out = data_r;
    assign bus.busy     = (state == ST_XFER);

    generate
        for (genvar d = 0; d < 4; d++) begin : g_cnt
            assign bus.cnt_dest[d*CNT_W +: CNT_W] = cnt_r[d];
        end
    endgenerate

endmodule : vc_dest_scheduler
`default_nettype wire

// File: tb/tb_vc_dest_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_dest_scheduler
// Description : Bench for vc_dest_scheduler: queue-based class FIFOs, a
//               transaction-level reference model and directed + random runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_dest_scheduler;

    localparam int WS = 12;
    localparam int CW = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_dest_scheduler_if #(.WORD_SIZE(WS), .CNT_W(CW)) bus ();

    vc_dest_scheduler #(.WORD_SIZE(WS), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Class FIFO contents (head at index 0)
    logic [WS-1:0] q [4][$];
    logic [3:0]    pop_log [$];

    // Stimulus knobs
    logic       rst_n;
    logic       mode;
    logic [3:0] afull;

    // Reference model: what the outputs must show after the current edge
    int         m_xfer;
    int         m_ptr;
    logic [3:0] m_pop, m_push;
    logic [WS-1:0] m_data;
    int         m_cnt [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WS-1:0] mk(input int cls, input int dst, input int pl);
        return {cls[1:0], dst[1:0], pl[7:0]};
    endfunction

    // Winner among eligible classes, -1 if none
    function automatic int pick(input logic [3:0] el, input logic rr, input int ptr);
        if (!rr) begin
            for (int i = 0; i < 4; i++) if (el[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (el[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic int dut_cnt(input int d);
        return int'(bus.cnt_dest[d*CW +: CW]);
    endfunction

    // One clock: drive, predict, advance, update FIFOs, compare
    task automatic cycle();
        logic [4*WS-1:0] cd;
        logic [3:0]      emp, el;
        int              s, n_xfer, n_ptr, n_cnt[4], d;
        logic [3:0]      n_pop, n_push;
        logic [WS-1:0]   n_data, w;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                cd[i*WS +: WS] = q[i][0];
                emp[i] = 1'b0;
            end else begin
                cd[i*WS +: WS] = WS'($urandom);
                emp[i] = 1'b1;
            end
        end
        bus.class_data  = cd;
        bus.class_empty = emp;
        bus.dest_afull  = afull;
        bus.mode_rr     = mode;
        reset           = rst_n;

        n_xfer = m_xfer; n_ptr = m_ptr; n_data = m_data;
        n_pop = 4'b0; n_push = 4'b0;
        for (int i = 0; i < 4; i++) n_cnt[i] = m_cnt[i];
        if (!rst_n) begin
            n_xfer = 0; n_ptr = 3; n_data = '0;
            for (int i = 0; i < 4; i++) n_cnt[i] = 0;
        end else if (m_xfer != 0) begin
            n_xfer = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                el[i] = !emp[i] && !afull[int'(cd[i*WS + WS - 4 +: 2])];
            end
            s = pick(el, mode, m_ptr);
            if (s >= 0) begin
                w        = q[s][0];
                d        = int'(w[WS-3 -: 2]);
                n_pop    = 4'(1 << s);
                n_push   = 4'(1 << d);
                n_data   = w;
                n_cnt[d] = (n_cnt[d] + 1) % (1 << CW);
                n_xfer   = 1;
                if (mode) n_ptr = s;
            end
        end

        @(posedge clk);
        // A FIFO consumes its head on an edge where pop is high and reset is not
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pop[i] && q[i].size() > 0) void'(q[i].pop_front());
            end
        end
        m_xfer = n_xfer; m_ptr = n_ptr; m_pop = n_pop; m_push = n_push; m_data = n_data;
        for (int i = 0; i < 4; i++) m_cnt[i] = n_cnt[i];

        #1;
        chk("pop",      bus.pop,      m_pop);
        chk("push",     bus.push,     m_push);
        chk("data_out", bus.data_out, m_data);
        chk("busy",     bus.busy,     (m_xfer != 0));
        for (int i = 0; i < 4; i++) chk($sformatf("cnt_dest[%0d]", i), dut_cnt(i), m_cnt[i]);
        if (bus.pop != 4'b0) pop_log.push_back(bus.pop);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 || m_xfer != 0) begin
            if (k >= budget) begin
                chk("drain_timeout", 1, 0);
                return;
            end
            cycle();
            k++;
        end
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; afull = 4'b0;
        m_xfer = 0; m_ptr = 3; m_pop = 0; m_push = 0; m_data = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        @(negedge clk);

        // Reset with every FIFO holding data
        for (int i = 0; i < 4; i++) for (int k = 0; k < 3; k++) q[i].push_back(mk(i, 0, k));
        do_reset(2);
        chk("rst_pop",  bus.pop, 0);
        chk("rst_push", bus.push, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_cnt",  bus.cnt_dest, 0);
        chk("rst_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) q[i].delete();

        // Round-robin fairness, all words to dest 0
        for (int i = 0; i < 4; i++) for (int k = 0; k < 5; k++) q[i].push_back(mk(i, 0, 16*i + k));
        mode = 1'b1; afull = 4'b0;
        do_reset(1);
        pop_log.delete();
        cycle();
        chk("rr_first_pop", bus.pop, 4'b0001);
        cycle();
        chk("rr_gap_pop", bus.pop, 4'b0000);
        drain(100);
        chk("rr_seq0", pop_log[0], 4'b0001);
        chk("rr_seq1", pop_log[1], 4'b0010);
        chk("rr_seq2", pop_log[2], 4'b0100);
        chk("rr_seq3", pop_log[3], 4'b1000);
        chk("rr_seq4", pop_log[4], 4'b0001);
        chk("rr_cnt0", dut_cnt(0), 20);

        // Strict priority: class 0 fully before class 2
        for (int k = 0; k < 3; k++) begin
            q[0].push_back(mk(0, 1, k));
            q[2].push_back(mk(2, 2, k));
        end
        mode = 1'b0;
        do_reset(1);
        pop_log.delete();
        drain(50);
        chk("sp_count", pop_log.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("sp_seq%0d", k), pop_log[k], (k < 3) ? 4'b0001 : 4'b0100);

        // Dest blocking: class 0 held by afull on its dest, class 1 proceeds
        q[0].push_back(mk(0, 1, 8'hA5));
        q[1].push_back(mk(1, 2, 8'h5A));
        mode = 1'b1; afull = 4'b0010;
        do_reset(1);
        pop_log.delete();
        repeat (5) cycle();
        chk("blk_pops", pop_log.size(), 1);
        chk("blk_first", pop_log[0], 4'b0010);
        chk("blk_held", q[0].size(), 1);
        afull = 4'b0000;
        repeat (4) cycle();
        chk("blk_release", pop_log[1], 4'b0001);
        chk("blk_drained", q[0].size(), 0);

        // Counter wrap: 32 words to dest 3, 2 words to dest 1
        do_reset(1);
        q[1].push_back(mk(1, 1, 1));
        q[1].push_back(mk(1, 1, 2));
        for (int k = 0; k < 32; k++) q[k % 4].push_back(mk(k % 4, 3, k));
        drain(200);
        chk("wrap_cnt3", dut_cnt(3), 0);
        chk("wrap_cnt1", dut_cnt(1), 2);
        chk("wrap_cnt0", dut_cnt(0), 0);
        chk("wrap_cnt2", dut_cnt(2), 0);

        // Reset while busy: word must stay queued and be re-sent
        do_reset(1);
        q[2].push_back(mk(2, 0, 8'h3C));
        begin
            int k = 0;
            while (bus.busy !== 1'b1 && k < 10) begin cycle(); k++; end
            chk("mid_busy_seen", bus.busy, 1);
        end
        rst_n = 1'b0;
        cycle();
        chk("mid_kept", q[2].size(), 1);
        chk("mid_nopop", bus.pop, 0);
        rst_n = 1'b1;
        cycle();
        chk("mid_resend", bus.pop, 4'b0100);
        chk("mid_resend_data", bus.data_out, mk(2, 0, 8'h3C));
        cycle();
        chk("mid_gone", q[2].size(), 0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() < 6 && $urandom_range(0, 3) == 0)
                    q[i].push_back(mk(i, $urandom_range(0, 3), $urandom_range(0, 255)));
            end
            afull = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 30) == 0) mode = ~mode;
            rst_n = ($urandom_range(0, 120) != 0);
            cycle();
        end
        rst_n = 1'b1; afull = 4'b0;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vc_dest_scheduler
`default_nettype wire
